// File: rtl/preg_free_list_pkg.sv
// Shared sizing and types for the physical-register free list.
// Rename and the ROB import the same definitions.
package preg_free_list_pkg;
    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned NUM_AREGS = 32;
    localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
    localparam int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int unsigned PTR_W     = $clog2(FL_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/preg_free_list_if.sv
// Rename/commit/flush bundle between the free list and its clients.
// The master side is rename plus the ROB.
interface preg_free_list_if;
    import preg_free_list_pkg::*;

    logic  alloc_valid_i;
    logic  alloc_ready_o;
    preg_t alloc_preg_o;
    logic  commit_valid_i;
    logic  commit_has_rd_i;
    preg_t commit_old_preg_i;
    logic  flush_i;
    cnt_t  free_count_o;

    modport master (
        output alloc_valid_i, commit_valid_i, commit_has_rd_i, commit_old_preg_i, flush_i,
        input  alloc_ready_o, alloc_preg_o, free_count_o
    );

    modport slave (
        input  alloc_valid_i, commit_valid_i, commit_has_rd_i, commit_old_preg_i, flush_i,
        output alloc_ready_o, alloc_preg_o, free_count_o
    );
endinterface

// File: rtl/preg_free_list.sv
// Circular free list of physical register IDs with a commit-side head,
// so a flush re-exposes every speculatively allocated preg in one cycle.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input logic             clk,
    input logic             rst,
    preg_free_list_if.slave fl_if
);

    preg_t fl [FL_DEPTH];
    ptr_t  spec_head;
    ptr_t  commit_head;
    ptr_t  tail;
    ptr_t  commit_head_next;
    cnt_t  spec_cnt;
    cnt_t  cmt_cnt;
    logic  ready;
    logic  pop;
    logic  push;

    always_comb begin
        ready = (spec_cnt != '0) && !fl_if.flush_i;
        pop   = fl_if.alloc_valid_i && ready;
        push  = fl_if.commit_valid_i && fl_if.commit_has_rd_i;
        commit_head_next = push ? commit_head + ptr_t'(1) : commit_head;
    end

    assign fl_if.alloc_ready_o = ready;
    assign fl_if.alloc_preg_o  = fl[spec_head];
    assign fl_if.free_count_o  = spec_cnt;

    // cmt_cnt holds its reset value: every push is paired with a commit_head advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                fl[i] <= PREG_W'(NUM_AREGS + i);
            end
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= '0;
            spec_cnt    <= CNT_W'(FL_DEPTH);
            cmt_cnt     <= CNT_W'(FL_DEPTH);
        end else begin
            if (push) begin
                fl[tail] <= fl_if.commit_old_preg_i;
                tail     <= tail + ptr_t'(1);
            end
            commit_head <= commit_head_next;
            if (fl_if.flush_i) begin
                spec_head <= commit_head_next;
                spec_cnt  <= cmt_cnt;
            end else begin
                if (pop) begin
                    spec_head <= spec_head + ptr_t'(1);
                end
                case ({push, pop})
                    2'b10:   spec_cnt <= spec_cnt + cnt_t'(1);
                    2'b01:   spec_cnt <= spec_cnt - cnt_t'(1);
                    default: spec_cnt <= spec_cnt;
                endcase
            end
        end
    end

    a_cnt_order: assert property (@(posedge clk) disable iff (rst)
        (spec_cnt <= cmt_cnt) && (cmt_cnt <= CNT_W'(FL_DEPTH)));

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (spec_cnt == CNT_W'(FL_DEPTH))));

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: directed scenarios plus a random
// rename/commit/flush stream checked against a queue-based free-list model.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    typedef struct {
        bit has_rd;
        int rd;
        int preg;
        int old;
    } rob_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Model: pregs visible to rename in order, and allocated-but-uncommitted pregs in order.
    int   free_q[$];
    int   inflight[$];
    rob_e rob[$];
    int   spec_map[32];
    int   cmt_map[32];

    preg_free_list_if bus ();

    preg_free_list dut (
        .clk   (clk),
        .rst   (rst),
        .fl_if (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        inflight.delete();
        rob.delete();
        for (int i = 0; i < int'(FL_DEPTH); i++) free_q.push_back(int'(NUM_AREGS) + i);
        for (int r = 0; r < 32; r++) begin
            spec_map[r] = r;
            cmt_map[r]  = r;
        end
    endtask

    // Called just after a posedge; returns just after the following posedge.
    task automatic do_reset(input bit busy);
        rst = 1'b1;
        bus.alloc_valid_i     = busy;
        bus.commit_valid_i    = busy;
        bus.commit_has_rd_i   = busy;
        bus.commit_old_preg_i = busy ? preg_t'(17) : '0;
        bus.flush_i           = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.alloc_valid_i   = 1'b0;
        bus.commit_valid_i  = 1'b0;
        bus.commit_has_rd_i = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_ready", {31'b0, bus.alloc_ready_o}, 32'd1);
        chk("reset_preg", {26'b0, bus.alloc_preg_o}, NUM_AREGS);
        chk("reset_count", {26'b0, bus.free_count_o}, FL_DEPTH);
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; checks outputs against the model mid-cycle, then advances the model.
    task automatic cycle(input bit av, input bit cv, input bit hr, input int old, input bit fl,
                         output bit fired, output int gp);
        bit exp_ready;
        bus.alloc_valid_i     = av;
        bus.commit_valid_i    = cv;
        bus.commit_has_rd_i   = hr;
        bus.commit_old_preg_i = preg_t'(old);
        bus.flush_i           = fl;
        @(negedge clk);
        exp_ready = (free_q.size() != 0) && !fl;
        chk("ready", {31'b0, bus.alloc_ready_o}, {31'b0, exp_ready});
        chk("count", {26'b0, bus.free_count_o}, free_q.size());
        if (exp_ready) chk("preg", {26'b0, bus.alloc_preg_o}, free_q[0]);
        fired = av && exp_ready;
        gp    = fired ? free_q[0] : -1;
        @(posedge clk);
        #1;
        if (cv && hr) void'(inflight.pop_front());
        if (fired) inflight.push_back(free_q.pop_front());
        if (cv && hr) free_q.push_back(old);
        if (fl) begin
            free_q = {inflight, free_q};
            inflight.delete();
        end
    endtask

    initial begin
        bit   fired;
        int   gp;
        bit   av, cv, hr, fl, disp, disp_rd;
        int   old, rd;
        rob_e e;
        int   seen[NUM_PREGS];
        bit   ok;

        bus.alloc_valid_i     = 1'b0;
        bus.commit_valid_i    = 1'b0;
        bus.commit_has_rd_i   = 1'b0;
        bus.commit_old_preg_i = '0;
        bus.flush_i           = 1'b0;
        #1;
        do_reset(1'b0);

        // 1: drain the whole list
        for (int i = 0; i < int'(FL_DEPTH); i++) begin
            cycle(1, 0, 0, 0, 0, fired, gp);
            chk("t1_grant", gp, int'(NUM_AREGS) + i);
        end
        cycle(1, 0, 0, 0, 0, fired, gp);
        chk("t1_empty_stall", {31'b0, fired}, 32'd0);

        // 2: push into an empty list; the same-cycle alloc must stall
        cycle(1, 1, 1, 5, 0, fired, gp);
        chk("t2_stall", {31'b0, fired}, 32'd0);
        cycle(1, 0, 0, 0, 0, fired, gp);
        chk("t2_grant", gp, 5);

        // 3: alloc 32,33,34, commit one (old=7), flush -> 33,34 reappear
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0, fired, gp);
            chk("t3_grant", gp, 32 + i);
        end
        cycle(0, 1, 1, 7, 0, fired, gp);
        chk("t3_count_pre", {26'b0, bus.free_count_o}, 32'd30);
        cycle(0, 0, 0, 0, 1, fired, gp);
        cycle(1, 0, 0, 0, 0, fired, gp);
        chk("t3_regrant_a", gp, 33);
        cycle(1, 0, 0, 0, 0, fired, gp);
        chk("t3_regrant_b", gp, 34);

        // 4: flush together with a commit (old=9); alloc blocked in that cycle only
        cycle(1, 1, 1, 9, 1, fired, gp);
        chk("t4_flush_stall", {31'b0, fired}, 32'd0);
        cycle(1, 0, 0, 0, 0, fired, gp);
        chk("t4_grant", gp, 34);

        // 5: random rename/commit/flush stream with an architectural map
        do_reset(1'b0);
        for (int c = 0; c < 200; c++) begin
            cv = 0; hr = 0; old = 0; fl = 0;
            if (rob.size() != 0 && $urandom_range(3) != 0) begin
                cv  = 1;
                e   = rob[0];
                hr  = e.has_rd;
                old = e.old;
            end
            if (rob.size() != 0 && $urandom_range(19) == 0) fl = 1;
            disp    = !fl && ($urandom_range(3) != 0);
            disp_rd = ($urandom_range(3) != 0);
            av      = disp && disp_rd;
            cycle(av, cv, hr, old, fl, fired, gp);
            if (cv) begin
                void'(rob.pop_front());
                if (e.has_rd) cmt_map[e.rd] = e.preg;
            end
            if (fl) begin
                rob.delete();
                spec_map = cmt_map;
            end else if (disp && !disp_rd) begin
                rob.push_back('{0, 0, 0, 0});
            end else if (fired) begin
                rd = int'($urandom_range(31, 1));
                rob.push_back('{1, rd, gp, spec_map[rd]});
                spec_map[rd] = gp;
            end
        end

        // committed map + in-flight + free list must cover every preg exactly once
        for (int p = 0; p < int'(NUM_PREGS); p++) seen[p] = 0;
        foreach (cmt_map[r]) seen[cmt_map[r]]++;
        foreach (rob[k]) if (rob[k].has_rd) seen[rob[k].preg]++;
        foreach (free_q[k]) seen[free_q[k]]++;
        ok = 1;
        for (int p = 0; p < int'(NUM_PREGS); p++) if (seen[p] != 1) ok = 0;
        chk("t5_partition", {31'b0, ok}, 32'd1);

        // drain: every remaining DUT entry is compared against the model in order
        while (free_q.size() != 0) cycle(1, 0, 0, 0, 0, fired, gp);
        chk("t5_drained", {26'b0, bus.free_count_o}, 32'd0);

        // 6: reset while alloc and commit are asserted
        cycle(1, 0, 0, 0, 0, fired, gp);
        do_reset(1'b1);
        cycle(1, 0, 0, 0, 0, fired, gp);
        chk("t6_first_grant", gp, int'(NUM_AREGS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
